layer4_argmax: RTL
==================

LAYER4_ARGMAX -- requirements
Module: layer4_argmax

Interface
REQ-001 Parameter N_NODES, default 32; number of layer-4 node outputs compared; legal range 2..64.
REQ-002 Parameter IDX_W, default 5; class index width; SHALL equal ceil(log2(N_NODES)).
REQ-003 Parameter NODE_LAT, default 3; clock edges from the node input sample to a valid node output.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: in_valid  in  1  high in the cycle the layer-4 node inputs carry a new sample.
REQ-007 Port: node_bus  in  8*N_NODES  node outputs; node k at bits [8k+7:8k], unsigned 0..127, or 0..255 tolerated.
REQ-008 Port: in_ready  out  1  high when a capture would be accepted (state IDLE or DONE).
REQ-009 Port: out_valid  out  1  one-cycle pulse, result fields valid.
REQ-010 Port: class_idx  out  IDX_W  index of the maximum node.
REQ-011 Port: class_val  out  8  value of the maximum node.
REQ-012 Port: busy  out  1  high while state is SCAN.
REQ-013 Port: overrun  out  1  sticky; a sample arrived while SCAN and was dropped.
REQ-014 Port: sample_cnt  out  16  count of completed classifications.

Function
REQ-015 Valid delay line of NODE_LAT registers SHALL shift in_valid; its last stage (cap_req) marks node_bus as valid.
REQ-016 FSM states SHALL be IDLE, SCAN, DONE.
REQ-017 In IDLE or DONE with cap_req=1, the block SHALL:
  - latch all of node_bus into an internal buffer;
  - set best_val=node0, best_idx=0, scan pointer=1;
  - enter SCAN.
REQ-018 In SCAN, one element per cycle: if buf[ptr] > best_val (unsigned, strict), best_val/best_idx SHALL take buf[ptr]/ptr; the pointer SHALL then increment.
REQ-019 Ties SHALL resolve to the lowest index (strict compare only).
REQ-020 After comparing element N_NODES-1, the FSM SHALL enter DONE with out_valid=1, class_idx=best_idx and class_val=best_val registered.
REQ-021 Latency: in_valid sampled at edge T -> capture at edge T+NODE_LAT -> out_valid high after edge T+NODE_LAT+N_NODES-1 (T+34 at defaults).
REQ-022 out_valid SHALL be high for exactly one cycle per capture.
REQ-023 class_idx and class_val SHALL hold their values until the next DONE.
REQ-024 DONE SHALL go to SCAN if cap_req=1, otherwise to IDLE; back-to-back samples are accepted with no gap.
REQ-025 cap_req=1 while in SCAN: the sample SHALL be dropped, overrun set to 1, and the scan left undisturbed.
REQ-026 sample_cnt SHALL increment on each out_valid and wrap 0xFFFF->0x0000.
REQ-027 node_bus changes during SCAN SHALL NOT affect the result (buffer only).

Reset
REQ-028 With reset=1 at a clock edge, all outputs SHALL be driven to 0: out_valid, class_idx, class_val, busy, overrun, sample_cnt.
REQ-029 Reset SHALL also clear the valid delay line, buffer, best_val, best_idx and pointer, and set state to IDLE; in_ready=1 after reset.
REQ-030 Reset asserted mid-SCAN SHALL abort with no out_valid.
REQ-031 Reset SHALL discard samples in flight in the delay line; no capture occurs from them.

Verification
REQ-032 Single sample, node7=100, others 10; in_valid pulse at edge T -> out_valid after edge T+34, class_idx=7, class_val=100, sample_cnt=1.
REQ-033 Tie case, node3=node20=127, others 0 -> class_idx=3, class_val=127.
REQ-034 All nodes 0 -> class_idx=0, class_val=0, out_valid still pulses.
REQ-035 Two in_valid pulses 10 cycles apart:
  - first result correct;
  - second sample dropped;
  - overrun=1;
  - only one out_valid;
  - sample_cnt=1.
REQ-036 in_valid pulses exactly 32 cycles apart -> second capture in the DONE cycle, two out_valid pulses 32 cycles apart, overrun=0.
REQ-037 Reset at edge T+20 after a capture -> no out_valid, all outputs 0, next sample classified correctly.

Source files
------------

// File: rtl/layer4_argmax.sv
// Layer-4 argmax: captures all node outputs once the valid delay line marks them settled,
// then scans one node per cycle and reports the index and value of the largest one.
module layer4_argmax #(
   parameter int N_NODES  = 32,
   parameter int IDX_W    = 5,
   parameter int NODE_LAT = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [8*N_NODES-1:0]   node_bus,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [IDX_W-1:0]       class_idx,
   output logic [7:0]             class_val,
   output logic                   busy,
   output logic                   overrun,
   output logic [15:0]            sample_cnt
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} stateT;

   stateT               state_q;
   stateT               stateD;
   logic [NODE_LAT-1:0] validDly_q;
   logic [7:0]          nodes_q [N_NODES];
   logic [7:0]          bestVal_q;
   logic [IDX_W-1:0]    bestIdx_q;
   logic [IDX_W-1:0]    ptr_q;
   logic                outValid_q;
   logic [IDX_W-1:0]    classIdx_q;
   logic [7:0]          classVal_q;
   logic                overrun_q;
   logic [15:0]         sampleCnt_q;

   logic                capReq;
   logic                lastElem;
   logic                doCapture;
   logic                doScan;
   logic                doFinish;
   logic                dropSample;
   logic                readyD;
   logic                busyD;
   logic [7:0]          curVal;
   logic [7:0]          candVal;
   logic [IDX_W-1:0]    candIdx;

   assign capReq   = validDly_q[NODE_LAT-1];
   assign lastElem = (ptr_q == IDX_W'(N_NODES - 1));

   // Valid delay line: node_bus is only trusted once in_valid has aged NODE_LAT edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         validDly_q <= '0;
      end else begin
         validDly_q[0] <= in_valid;
         for (int i = 1; i < NODE_LAT; i++) begin
            validDly_q[i] <= validDly_q[i-1];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= stateD;
      end
   end

   // FSM next-state logic; DONE may chain straight into a new scan.
   always_comb begin
      stateD = state_q;
      case (state_q)
         IDLE:    if (capReq) stateD = SCAN;
         SCAN:    if (lastElem) stateD = DONE;
         DONE:    stateD = capReq ? SCAN : IDLE;
         default: stateD = IDLE;
      endcase
   end

   // FSM output decode driving the datapath strobes and status flags.
   always_comb begin
      doCapture  = 1'b0;
      doScan     = 1'b0;
      doFinish   = 1'b0;
      dropSample = 1'b0;
      readyD     = 1'b1;
      busyD      = 1'b0;
      if (state_q == SCAN) begin
         doScan     = 1'b1;
         doFinish   = lastElem;
         dropSample = capReq;
         readyD     = 1'b0;
         busyD      = 1'b1;
      end else begin
         doCapture  = capReq;
      end
   end

   // Strict compare means an equal later node never displaces the earlier winner.
   always_comb begin
      curVal  = nodes_q[ptr_q];
      candVal = bestVal_q;
      candIdx = bestIdx_q;
      if (curVal > bestVal_q) begin
         candVal = curVal;
         candIdx = ptr_q;
      end
   end

   // Capture buffer and running best; the buffer isolates the scan from node_bus changes.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N_NODES; k++) begin
            nodes_q[k] <= '0;
         end
         bestVal_q <= '0;
         bestIdx_q <= '0;
         ptr_q     <= '0;
      end else if (doCapture) begin
         for (int k = 0; k < N_NODES; k++) begin
            nodes_q[k] <= node_bus[8*k +: 8];
         end
         bestVal_q <= node_bus[7:0];
         bestIdx_q <= '0;
         ptr_q     <= IDX_W'(1);
      end else if (doScan) begin
         bestVal_q <= candVal;
         bestIdx_q <= candIdx;
         ptr_q     <= ptr_q + IDX_W'(1);
      end
   end

   // Result registers hold until the next completed scan.
   always_ff @(posedge clk) begin
      if (reset) begin
         outValid_q  <= 1'b0;
         classIdx_q  <= '0;
         classVal_q  <= '0;
         sampleCnt_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         outValid_q <= doFinish;
         if (doFinish) begin
            classIdx_q  <= candIdx;
            classVal_q  <= candVal;
            sampleCnt_q <= sampleCnt_q + 16'd1;
         end
         if (dropSample) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign in_ready   = readyD;
   assign busy       = busyD;
   assign out_valid  = outValid_q;
   assign class_idx  = classIdx_q;
   assign class_val  = classVal_q;
   assign overrun    = overrun_q;
   assign sample_cnt = sampleCnt_q;

endmodule
